// File: rtl/self_test_pkg.sv
// Shared types and frame geometry for the stacked-die enumeration engine.
package self_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_WAIT,
        TX_LOAD,
        TX,
        ACK_WAIT,
        DONE,
        FAIL
    } state_t;

    localparam logic [3:0]  HDR_DEFAULT  = 4'hA;
    localparam logic [15:0] SYNC_DEFAULT = 16'hBEEF;
    localparam int          SYNC_W       = 16;
    localparam int          HDR_W        = 4;

    // Frame, MSB to LSB: {hdr, power, own_id, next_id, sync}
    function automatic int next_id_lsb();
        return SYNC_W;
    endfunction

    function automatic int own_id_lsb(input int id_w);
        return SYNC_W + id_w;
    endfunction

    function automatic int pwr_lsb(input int id_w);
        return SYNC_W + 2 * id_w;
    endfunction

    function automatic int frame_width(input int id_w, input int pwr_w);
        return HDR_W + pwr_w + 2 * id_w + SYNC_W;
    endfunction

endpackage

// File: rtl/self_test_frame_codec.sv
// Combinational frame packer for the beacon and field extractor for received frames.
module self_test_frame_codec
    import self_test_pkg::*;
#(
    parameter int          ID_W   = 4,
    parameter int          PWR_W  = 4,
    parameter logic [3:0]  HDR    = HDR_DEFAULT,
    parameter logic [15:0] SYNC   = SYNC_DEFAULT,
    parameter int          DATA_W = frame_width(ID_W, PWR_W)
) (
    input  logic [PWR_W-1:0]  i_pwr,
    input  logic [ID_W-1:0]   i_own_id,
    input  logic [ID_W-1:0]   i_next_id,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [DATA_W-1:0] o_frame,
    output logic              o_rx_sync_ok,
    output logic [ID_W-1:0]   o_rx_own_id,
    output logic [ID_W-1:0]   o_rx_next_id
);

    localparam int NEXT_LSB = next_id_lsb();
    localparam int OWN_LSB  = own_id_lsb(ID_W);
    localparam int PWR_LSB  = pwr_lsb(ID_W);

    // Header and power of a received frame carry no meaning for this layer.
    logic w_unused_fields;

    assign o_frame         = {HDR, i_pwr, i_own_id, i_next_id, SYNC};
    assign o_rx_sync_ok    = (i_data_in[SYNC_W-1:0] == SYNC);
    assign o_rx_own_id     = i_data_in[OWN_LSB +: ID_W];
    assign o_rx_next_id    = i_data_in[NEXT_LSB +: ID_W];
    assign w_unused_fields = &i_data_in[DATA_W-1:PWR_LSB];

endmodule

// File: rtl/self_test_enum.sv
// Per-layer chip-ID enumeration: learn/assign ID, beacon next ID upward with rising drive power.
module self_test_enum
    import self_test_pkg::*;
#(
    parameter int          ID_W     = 4,
    parameter int          PWR_W    = 4,
    parameter logic [3:0]  HDR      = HDR_DEFAULT,
    parameter logic [15:0] SYNC     = SYNC_DEFAULT,
    parameter int          TIMEOUT  = 20,
    parameter int          PWR_STEP = 1
) (
    input  logic                          div_8_clk,
    input  logic                          rst,
    input  logic                          f_layer,
    input  logic                          start,
    input  logic                          rx_valid,
    input  logic [20+PWR_W+2*ID_W-1:0]    data_in,
    input  logic                          tx_ready,
    output logic                          tx_valid,
    output logic [20+PWR_W+2*ID_W-1:0]    data_out,
    output logic [ID_W-1:0]               chip_id,
    output logic [PWR_W-1:0]              power_value,
    output logic                          sort_finish,
    output logic                          last_layer,
    output logic                          fail
);

    localparam int                DATA_W   = frame_width(ID_W, PWR_W);
    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PWR_W-1:0]  PWR_MAX  = '1;

    state_t              r_state;
    logic                r_tx_valid;
    logic [DATA_W-1:0]   r_data_out;
    logic [ID_W-1:0]     r_chip_id;
    logic [PWR_W-1:0]    r_power;
    logic                r_last_layer;
    logic [CNT_W-1:0]    r_cnt;

    state_t              w_state_nxt;
    logic                w_tx_valid_nxt;
    logic [DATA_W-1:0]   w_data_out_nxt;
    logic [ID_W-1:0]     w_chip_id_nxt;
    logic [PWR_W-1:0]    w_power_nxt;
    logic                w_last_layer_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic [PWR_W:0]      w_pwr_sum;
    logic [PWR_W-1:0]    w_pwr_inc;
    logic [ID_W-1:0]     w_id_plus1;
    logic [DATA_W-1:0]   w_frame;
    logic                w_sync_ok;
    logic [ID_W-1:0]     w_rx_own_id;
    logic [ID_W-1:0]     w_rx_next_id;
    logic                w_rx_frame;
    logic                w_ack;

    // One bit of headroom so the saturation clamp sees the carry.
    assign w_pwr_sum  = {1'b0, r_power} + (PWR_W + 1)'(PWR_STEP);
    assign w_pwr_inc  = (w_pwr_sum > {1'b0, PWR_MAX}) ? PWR_MAX : w_pwr_sum[PWR_W-1:0];
    assign w_id_plus1 = r_chip_id + ID_W'(1);
    assign w_rx_frame = rx_valid && w_sync_ok;
    assign w_ack      = w_rx_frame && (w_rx_own_id == w_id_plus1);

    self_test_frame_codec #(
        .ID_W   (ID_W),
        .PWR_W  (PWR_W),
        .HDR    (HDR),
        .SYNC   (SYNC),
        .DATA_W (DATA_W)
    ) u_codec (
        .i_pwr        (w_pwr_inc),
        .i_own_id     (r_chip_id),
        .i_next_id    (w_id_plus1),
        .i_data_in    (data_in),
        .o_frame      (w_frame),
        .o_rx_sync_ok (w_sync_ok),
        .o_rx_own_id  (w_rx_own_id),
        .o_rx_next_id (w_rx_next_id)
    );

    always_ff @(posedge div_8_clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tx_valid   <= 1'b0;
            r_data_out   <= '0;
            r_chip_id    <= '0;
            r_power      <= '0;
            r_last_layer <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_data_out   <= w_data_out_nxt;
            r_chip_id    <= w_chip_id_nxt;
            r_power      <= w_power_nxt;
            r_last_layer <= w_last_layer_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tx_valid_nxt   = r_tx_valid;
        w_data_out_nxt   = r_data_out;
        w_chip_id_nxt    = r_chip_id;
        w_power_nxt      = r_power;
        w_last_layer_nxt = r_last_layer;
        w_cnt_nxt        = r_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (f_layer) begin
                        w_chip_id_nxt = ID_W'(1);
                        w_state_nxt   = TX_LOAD;
                    end else begin
                        w_state_nxt   = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                if (w_rx_frame) begin
                    w_chip_id_nxt = w_rx_next_id;
                    w_state_nxt   = ((w_rx_next_id == '0) || (w_rx_next_id == '1)) ? FAIL : TX_LOAD;
                end
            end
            TX_LOAD: begin
                w_power_nxt    = w_pwr_inc;
                w_data_out_nxt = w_frame;
                w_tx_valid_nxt = 1'b1;
                w_cnt_nxt      = '0;
                w_state_nxt    = TX;
            end
            TX: begin
                if (tx_ready) begin
                    w_tx_valid_nxt = 1'b0;
                    w_data_out_nxt = '0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ACK_WAIT;
                end else if (r_cnt == CNT_LAST) begin
                    // Link stalled: withdraw the frame rather than leave it dangling.
                    w_tx_valid_nxt = 1'b0;
                    w_data_out_nxt = '0;
                    w_state_nxt    = FAIL;
                end else begin
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                end
            end
            ACK_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_ack) begin
                    w_state_nxt = DONE;
                end else if (r_cnt == CNT_LAST) begin
                    if (r_power == PWR_MAX) begin
                        w_last_layer_nxt = 1'b1;
                        w_state_nxt      = DONE;
                    end else begin
                        w_state_nxt      = TX_LOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    assign tx_valid    = r_tx_valid;
    assign data_out    = r_data_out;
    assign chip_id     = r_chip_id;
    assign power_value = r_power;
    assign last_layer  = r_last_layer;
    assign sort_finish = (r_state == DONE);
    assign fail        = (r_state == FAIL);

endmodule

// File: tb/tb_self_test_enum.sv
// Scoreboard bench for self_test_enum: expected beacon frames queued at stimulus, checked at tx accept.
module tb_self_test_enum;

    localparam int T = 20;

    logic        div_8_clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_layer = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [31:0] data_out;
    logic [3:0]  chip_id;
    logic [3:0]  power_value;
    logic        sort_finish;
    logic        last_layer;
    logic        fail;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tx_valid_cnt = 0;
    logic [31:0] exp_q[$];
    int          acc_q[$];

    self_test_enum dut (
        .div_8_clk   (div_8_clk),
        .rst         (rst),
        .f_layer     (f_layer),
        .start       (start),
        .rx_valid    (rx_valid),
        .data_in     (data_in),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .data_out    (data_out),
        .chip_id     (chip_id),
        .power_value (power_value),
        .sort_finish (sort_finish),
        .last_layer  (last_layer),
        .fail        (fail)
    );

    always #5 div_8_clk = ~div_8_clk;
    always @(posedge div_8_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_frame(input logic [3:0] pwr, input logic [3:0] own, input logic [3:0] nxt);
        return {4'hA, pwr, own, nxt, 16'hBEEF};
    endfunction

    always @(negedge div_8_clk) begin
        if (!rst) begin
            if (tx_valid) tx_valid_cnt++;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("tx_unexpected", exp_q.size(), 1);
                end else begin
                    chk("tx_frame", data_out, exp_q.pop_front());
                    acc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge div_8_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; data_in = '0; tx_ready = 1'b0;
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge div_8_clk);
        #1;
        rst = 1'b0;
        tx_valid_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_rx(input logic [31:0] f);
        rx_valid = 1'b1;
        data_in  = f;
        tick();
        rx_valid = 1'b0;
        data_in  = '0;
    endtask

    task automatic wait_tx(input int budget);
        int n = 0;
        while (!tx_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_tx", tx_valid, 1);
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(sort_finish || fail) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_end", sort_finish | fail, 1);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, {tx_valid, sort_finish, last_layer, fail, chip_id, power_value, data_out}, '0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_outs_zero("reset_outs");

        // First layer, acknowledged on first attempt
        f_layer = 1'b1; tx_ready = 1'b1;
        exp_q.push_back(mk_frame(4'd1, 4'd1, 4'd2));
        pulse_start();
        wait_tx(10);
        tick();
        chk("accept_clears", {tx_valid, data_out}, '0);
        tick();
        send_rx(mk_frame(4'd0, 4'd2, 4'd3));
        wait_end(10);
        chk("t1_flags", {sort_finish, last_layer, fail}, 3'b100);
        chk("t1_chip_id", chip_id, 4'd1);
        chk("t1_q_empty", exp_q.size(), 0);

        // Upper layer learns ID 3; bad-sync frame ignored first
        do_reset();
        f_layer = 1'b0; tx_ready = 1'b1;
        exp_q.push_back(mk_frame(4'd1, 4'd3, 4'd4));
        pulse_start();
        send_rx({4'hA, 4'h0, 4'h4, 4'h5, 16'hBEEE});
        chk("badsync_ignored", chip_id, 4'd0);
        send_rx({4'hA, 4'h0, 4'h2, 4'h3, 16'hBEEF});
        chk("t2_chip_id", chip_id, 4'd3);
        wait_tx(10);
        tick();
        chk("t2_q_empty", exp_q.size(), 0);

        // No acknowledge: 15 attempts then top-of-stack
        do_reset();
        f_layer = 1'b1; tx_ready = 1'b1;
        for (int p = 1; p <= 15; p++) exp_q.push_back(mk_frame(4'(p), 4'd1, 4'd2));
        pulse_start();
        wait_tx(10);
        repeat (4) tick();
        send_rx(mk_frame(4'd0, 4'd3, 4'd4));
        wait_end(800);
        chk("t3_flags", {sort_finish, last_layer, fail}, 3'b110);
        chk("t3_power", power_value, 4'd15);
        chk("t3_q_empty", exp_q.size(), 0);
        chk("t3_attempts", acc_q.size(), 15);
        for (int i = 1; i < acc_q.size(); i++) chk("t3_gap", acc_q[i] - acc_q[i-1], T + 2);

        // Received next_id all-ones and zero both abort without transmitting
        do_reset();
        f_layer = 1'b0; tx_ready = 1'b1;
        pulse_start();
        send_rx({4'hA, 4'h0, 4'h2, 4'hF, 16'hBEEF});
        wait_end(10);
        chk("t4_flags", {sort_finish, last_layer, fail}, 3'b001);
        chk("t4_chip_id", chip_id, 4'hF);
        repeat (3) tick();
        chk("t4_no_tx", tx_valid_cnt, 0);
        do_reset();
        f_layer = 1'b0; tx_ready = 1'b1;
        pulse_start();
        send_rx({4'hA, 4'h0, 4'h2, 4'h0, 16'hBEEF});
        wait_end(10);
        chk("t4b_fail", fail, 1);
        chk("t4b_no_tx", tx_valid_cnt, 0);

        // tx_ready held low for the full window
        do_reset();
        f_layer = 1'b1; tx_ready = 1'b0;
        pulse_start();
        wait_end(100);
        chk("t5_flags", {sort_finish, fail, tx_valid}, 3'b010);
        chk("t5_valid_cycles", tx_valid_cnt, T);

        // tx_ready rises on the last allowed cycle
        do_reset();
        f_layer = 1'b1; tx_ready = 1'b0;
        exp_q.push_back(mk_frame(4'd1, 4'd1, 4'd2));
        pulse_start();
        wait_tx(10);
        repeat (T - 1) tick();
        tx_ready = 1'b1;
        tick();
        chk("t5b_accept", {fail, tx_valid}, 2'b00);
        chk("t5b_q_empty", exp_q.size(), 0);

        // Acknowledge on the timeout cycle at max power
        do_reset();
        f_layer = 1'b1; tx_ready = 1'b1;
        for (int p = 1; p <= 15; p++) exp_q.push_back(mk_frame(4'(p), 4'd1, 4'd2));
        pulse_start();
        begin
            int n = 0;
            while (!(tx_valid && power_value == 4'd15) && n < 800) begin
                tick();
                n++;
            end
            chk("t6_reach_max", {tx_valid, power_value}, {1'b1, 4'd15});
        end
        tick();
        repeat (T - 1) tick();
        chk("t6_pre_ack", {sort_finish, last_layer}, 2'b00);
        send_rx(mk_frame(4'd0, 4'd2, 4'd3));
        chk("t6_flags", {sort_finish, last_layer, fail}, 3'b100);
        chk("t6_q_empty", exp_q.size(), 0);

        // Reset mid-ACK_WAIT, then re-enumerate from power 0
        do_reset();
        f_layer = 1'b1; tx_ready = 1'b1;
        exp_q.push_back(mk_frame(4'd1, 4'd1, 4'd2));
        pulse_start();
        wait_tx(10);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk_outs_zero("t7_async_rst");
        do_reset();
        f_layer = 1'b1; tx_ready = 1'b1;
        exp_q.push_back(mk_frame(4'd1, 4'd1, 4'd2));
        pulse_start();
        wait_tx(10);
        chk("t7_power", power_value, 4'd1);
        tick();
        send_rx(mk_frame(4'd0, 4'd2, 4'd3));
        wait_end(10);
        chk("t7_flags", {sort_finish, last_layer, fail}, 3'b100);
        chk("t7_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
